// File: rtl/cache_arbiter_if.sv
// Bundle of the two requester ports and the single-port cache request/response bus.
// master = arbiter side, slave = requesters plus cache side.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rq0_req;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_data;
    logic              rq0_type;
    logic              rq0_done;
    logic [DATA_W-1:0] rq0_rdata;
    logic              rq0_err;

    logic              rq1_req;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_data;
    logic              rq1_type;
    logic              rq1_done;
    logic [DATA_W-1:0] rq1_rdata;
    logic              rq1_err;

    logic [ADDR_W-1:0] c_req_addr;
    logic [DATA_W-1:0] c_req_data;
    logic              c_req_type;
    logic              c_req_do;
    logic [DATA_W-1:0] c_O_data;
    logic              c_req_done;

    modport master (
        input  rq0_req, rq0_addr, rq0_data, rq0_type,
        output rq0_done, rq0_rdata, rq0_err,
        input  rq1_req, rq1_addr, rq1_data, rq1_type,
        output rq1_done, rq1_rdata, rq1_err,
        output c_req_addr, c_req_data, c_req_type, c_req_do,
        input  c_O_data, c_req_done
    );

    modport slave (
        output rq0_req, rq0_addr, rq0_data, rq0_type,
        input  rq0_done, rq0_rdata, rq0_err,
        output rq1_req, rq1_addr, rq1_data, rq1_type,
        input  rq1_done, rq1_rdata, rq1_err,
        input  c_req_addr, c_req_data, c_req_type, c_req_do,
        output c_O_data, c_req_done
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one single-port cache between rq0 (ifetch) and rq1 (data).
// Optional WAIT watchdog with DRAIN state when CACHE_ARB_TIMEOUT_EN is defined (adds TIMEOUT_CYCLES).
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef CACHE_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic              prio, owner, grant, any_req;
    logic              timeout, drain_needed;
    logic              req_do, lat_type;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data, resp_data;
    logic [1:0]        done_q;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_WAIT && (bus.c_req_done || timeout))
                err_q <= timeout;
        end
    end

    // A c_req_done on the limit cycle wins, so timeout requires its absence.
    assign timeout      = (state == S_WAIT) && !bus.c_req_done &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drain_needed = err_q && !bus.c_req_done;
    assign bus.rq0_err  = done_q[0] & err_q;
    assign bus.rq1_err  = done_q[1] & err_q;
`else
    assign timeout      = 1'b0;
    assign drain_needed = 1'b0;
    assign bus.rq0_err  = 1'b0;
    assign bus.rq1_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        any_req   = bus.rq0_req | bus.rq1_req;
        grant     = (bus.rq0_req & bus.rq1_req) ? prio : bus.rq1_req;
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.c_req_done || timeout) state_nxt = S_RESP;
            S_RESP:  state_nxt = drain_needed ? S_DRAIN : S_IDLE;
            S_DRAIN: if (bus.c_req_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio      <= 1'b0;
            owner     <= 1'b0;
            req_do    <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_type  <= 1'b0;
            resp_data <= '0;
            done_q    <= 2'b00;
        end else begin
            req_do <= 1'b0;
            done_q <= 2'b00;
            if (state == S_IDLE && any_req) begin
                owner    <= grant;
                prio     <= ~grant;
                lat_addr <= grant ? bus.rq1_addr : bus.rq0_addr;
                lat_data <= grant ? bus.rq1_data : bus.rq0_data;
                lat_type <= grant ? bus.rq1_type : bus.rq0_type;
                req_do   <= 1'b1;
            end
            if (state == S_WAIT && (bus.c_req_done || timeout)) begin
                resp_data <= (bus.c_req_done && !lat_type) ? bus.c_O_data : '0;
                done_q    <= owner ? 2'b10 : 2'b01;
            end
        end
    end

    assign bus.c_req_do   = req_do;
    assign bus.c_req_addr = lat_addr;
    assign bus.c_req_data = lat_data;
    assign bus.c_req_type = lat_type;
    assign bus.rq0_done   = done_q[0];
    assign bus.rq1_done   = done_q[1];
    assign bus.rq0_rdata  = done_q[0] ? resp_data : '0;
    assign bus.rq1_rdata  = done_q[1] ? resp_data : '0;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a 3-cycle-hit cache model; timeout case runs when
// CACHE_ARB_TIMEOUT_EN is defined.
module tb_cache_arbiter;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_do = 0, n_done0 = 0, n_done1 = 0;
    bit   mute = 0;
    int   inject_req = 0;

    cache_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_ARB_TIMEOUT_EN
    cache_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
`else
    cache_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.c_req_do) n_do++;
        if (bus.rq0_done) n_done0++;
        if (bus.rq1_done) n_done1++;
    end

    // Cache model: done pulse 3 cycles after the c_req_do cycle; reads of unknown words return ~addr.
    initial begin
        logic [31:0] mem [logic [31:0]];
        int          pend;
        int          inject_seen;
        logic [31:0] p_addr, p_data;
        logic        p_type;
        mem[32'h0000_0040] = 32'h1234_5678;
        pend = 0;
        inject_seen = 0;
        p_addr = '0; p_data = '0; p_type = 1'b0;
        bus.c_req_done = 1'b0;
        bus.c_O_data   = '0;
        forever begin
            @(negedge clk);
            bus.c_req_done = 1'b0;
            bus.c_O_data   = '0;
            if (reset) begin
                pend = 0;
            end else begin
                if (inject_seen != inject_req) begin
                    inject_seen    = inject_req;
                    bus.c_req_done = 1'b1;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.c_req_done = 1'b1;
                        if (p_type)
                            mem[p_addr] = p_data;
                        else
                            bus.c_O_data = mem.exists(p_addr) ? mem[p_addr] : ~p_addr;
                    end
                end
                if (bus.c_req_do && pend == 0 && !mute) begin
                    p_addr = bus.c_req_addr;
                    p_data = bus.c_req_data;
                    p_type = bus.c_req_type;
                    pend   = 3;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic t);
        if (p == 0) begin
            bus.rq0_req = r; bus.rq0_addr = a; bus.rq0_data = d; bus.rq0_type = t;
        end else begin
            bus.rq1_req = r; bus.rq1_addr = a; bus.rq1_data = d; bus.rq1_type = t;
        end
    endtask

    function automatic logic port_done(input int p);
        return (p == 0) ? bus.rq0_done : bus.rq1_done;
    endfunction

    function automatic logic [31:0] port_rdata(input int p);
        return (p == 0) ? bus.rq0_rdata : bus.rq1_rdata;
    endfunction

    // Drives one request in an IDLE cycle; lat = cycles until done, do_lat = cycles until c_req_do.
    task automatic run_req(input int p, input logic [31:0] a, input logic [31:0] d, input logic t,
                           output logic [31:0] rd, output int lat, output int do_lat);
        @(posedge clk); #1;
        drive_port(p, 1'b1, a, d, t);
        lat = 0;
        do_lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (bus.c_req_do && do_lat == 0) do_lat = lat;
        end while (!port_done(p) && lat < 40);
        rd = port_rdata(p);
        drive_port(p, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, do_lat, b0, b1, bdo, cnt;
        int g_cyc [4];

        reset = 1'b1;
        drive_port(0, 1'b0, '0, '0, 1'b0);
        drive_port(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_c_req_do", bus.c_req_do, 0);
        check_val("rst_rq0_done", bus.rq0_done, 0);
        check_val("rst_rq1_done", bus.rq1_done, 0);
        check_val("rst_rq0_rdata", bus.rq0_rdata, 0);
        check_val("rst_c_req_addr", bus.c_req_addr, 0);
        check_val("rst_rq1_err", bus.rq1_err, 0);
        @(negedge clk) reset = 1'b0;

        // 1: rq0 read hit
        b0 = n_done0; b1 = n_done1;
        run_req(0, 32'h0000_0040, '0, 1'b0, rd, lat, do_lat);
        check_val("t1_do_cycle", do_lat, 1);
        check_val("t1_done_cycle", lat, 5);
        check_val("t1_rdata", rd, 32'h1234_5678);
        check_val("t1_err", bus.rq0_err, 0);
        @(negedge clk);
        check_val("t1_done0_cnt", n_done0 - b0, 1);
        check_val("t1_done1_cnt", n_done1 - b1, 0);
        @(posedge clk); #1;
        check_val("t1_rdata_idle", bus.rq0_rdata, 0);

        // 2: rq1 write then rq0 read-back
        b0 = n_done0; b1 = n_done1;
        run_req(1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, rd, lat, do_lat);
        check_val("t2_wr_lat", lat, 5);
        check_val("t2_wr_rdata", rd, 0);
        check_val("t2_wr_addr", bus.c_req_addr, 32'h0000_0100);
        run_req(0, 32'h0000_0100, '0, 1'b0, rd, lat, do_lat);
        check_val("t2_rd_lat", lat, 5);
        check_val("t2_rd_rdata", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("t2_done0_cnt", n_done0 - b0, 1);
        check_val("t2_done1_cnt", n_done1 - b1, 1);

        // 3: both requesting from reset alternate 0,1,0,1
        #1 reset = 1'b1;
        drive_port(0, 1'b1, 32'h0000_0200, '0, 1'b0);
        drive_port(1, 1'b1, 32'h0000_0300, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        b0 = n_done0; b1 = n_done1;
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            do begin @(posedge clk); #1; cnt++; end while (!bus.c_req_do && cnt < 40);
            g_cyc[g] = cyc;
            check_val($sformatf("t3_grant%0d_addr", g), bus.c_req_addr,
                      (g % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300);
        end
        drive_port(0, 1'b0, '0, '0, 1'b0);
        drive_port(1, 1'b0, '0, '0, 1'b0);
        check_val("t3_grant_gap", g_cyc[1] - g_cyc[0], 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("t3_done0_cnt", n_done0 - b0, 2);
        check_val("t3_done1_cnt", n_done1 - b1, 2);

        // 4: reset while in WAIT
        @(posedge clk); #1;
        drive_port(0, 1'b1, 32'h0000_0040, '0, 1'b0);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.c_req_do && cnt < 40);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        drive_port(0, 1'b0, '0, '0, 1'b0);
        #1;
        check_val("t4_rst_addr", bus.c_req_addr, 0);
        check_val("t4_rst_do", bus.c_req_do, 0);
        @(negedge clk) reset = 1'b0;
        b0 = n_done0; bdo = n_do;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("t4_no_done", n_done0 - b0, 0);
        check_val("t4_no_do", n_do - bdo, 0);
        run_req(0, 32'h0000_0040, '0, 1'b0, rd, lat, do_lat);
        check_val("t4_fresh_lat", lat, 5);
        check_val("t4_fresh_rdata", rd, 32'h1234_5678);

        // 5: rq1 drops req right after its grant
        @(posedge clk); #1;
        b1 = n_done1; bdo = n_do;
        drive_port(1, 1'b1, 32'h0000_0100, '0, 1'b0);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.c_req_do && cnt < 40);
        drive_port(1, 1'b0, '0, '0, 1'b0);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.rq1_done && cnt < 40);
        check_val("t5_rdata", bus.rq1_rdata, 32'hDEAD_BEEF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("t5_done1_cnt", n_done1 - b1, 1);
        check_val("t5_do_cnt", n_do - bdo, 1);

`ifdef CACHE_ARB_TIMEOUT_EN
        // 6: cache never answers; watchdog responds with error, then drains
        @(posedge clk); #1;
        mute = 1'b1;
        bdo = n_do;
        drive_port(0, 1'b1, 32'h0000_0040, '0, 1'b0);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.c_req_do && cnt < 40);
        g_cyc[0] = cyc;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.rq0_done && cnt < 40);
        check_val("t6_to_cycle", cyc - g_cyc[0], 9);
        check_val("t6_err", bus.rq0_err, 1);
        check_val("t6_rdata", bus.rq0_rdata, 0);
        drive_port(0, 1'b0, '0, '0, 1'b0);
        drive_port(1, 1'b1, 32'h0000_0100, '0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("t6_no_grant", n_do - bdo, 1);
        mute = 1'b0;
        inject_req++;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!bus.rq1_done && cnt < 40);
        check_val("t6_rq1_rdata", bus.rq1_rdata, 32'hDEAD_BEEF);
        check_val("t6_rq1_err", bus.rq1_err, 0);
        drive_port(1, 1'b0, '0, '0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end
endmodule
